// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle for sync_fifo_prog.
// The FIFO binds to the slave modport and the producer/consumer side binds to master.
interface sync_fifo_prog_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic [ASIZE:0]   af_thresh;
    logic [ASIZE:0]   ae_thresh;
    logic             clr_err;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             almost_full;
    logic             almost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wdata, winc, rinc, af_thresh, ae_thresh, clr_err,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, af_thresh, ae_thresh, clr_err,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with run-time almost-full/empty thresholds, occupancy count,
// sticky overflow/underflow flags and a choice of standard or FWFT read mode.
module sync_fifo_prog #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_prog_if.slave  bus
);
    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE + 1)'(DEPTH);

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full, empty, wrAccept, rdAccept;

    // Every flag derives from the registered count, so none can follow winc/rinc combinationally
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign wrAccept = bus.winc && !full;
    assign rdAccept = bus.rinc && !empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wrAccept) wptr_d = wptr_q + 1'b1;
        if (rdAccept) rptr_d = rptr_q + 1'b1;

        case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A fresh error on this edge wins over clr_err
        if (bus.winc && full)       overflow_d = 1'b1;
        else if (bus.clr_err)       overflow_d = 1'b0;
        if (bus.rinc && empty)      underflow_d = 1'b1;
        else if (bus.clr_err)       underflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrAccept) mem[wptr_q] <= bus.wdata;
    end

    generate
        if (FWFT != 0) begin : gFwft
            assign bus.rdata = mem[rptr_q];
        end else begin : gStd
            logic [DSIZE-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (rdAccept) rdata_d = mem[rptr_q];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdata_q <= '0;
                else        rdata_q <= rdata_d;
            end

            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.wfull        = full;
    assign bus.rempty       = empty;
    assign bus.almost_full  = (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a standard-mode instance driven from a vector table
// and hand sequences, plus an FWFT instance for the fall-through corner cases.
module tb_sync_fifo_prog;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       winc;
        logic       rinc;
        logic       clr;
        logic [7:0] wdata;
        logic [4:0] expCount;
        logic [7:0] expRdata;
        logic       expEmpty;
        logic       expFull;
        logic       expOvf;
        logic       expUdf;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model[$];

    sync_fifo_prog_if #(.DSIZE(8), .ASIZE(4)) b0 ();
    sync_fifo_prog_if #(.DSIZE(8), .ASIZE(4)) b1 ();

    sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FWFT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FWFT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic w, input logic r, input logic c, input logic [7:0] d,
                                   input logic [4:0] cnt, input logic [7:0] rd, input logic emp,
                                   input logic ful, input logic ovf, input logic udf);
        vec_t v;
        v.winc = w; v.rinc = r; v.clr = c; v.wdata = d;
        v.expCount = cnt; v.expRdata = rd; v.expEmpty = emp;
        v.expFull = ful; v.expOvf = ovf; v.expUdf = udf;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        b0.winc    = v.winc;
        b0.rinc    = v.rinc;
        b0.clr_err = v.clr;
        b0.wdata   = v.wdata;
        tick();
        b0.winc    = 1'b0;
        b0.rinc    = 1'b0;
        b0.clr_err = 1'b0;
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d count", idx), 32'(b0.count), 32'(v.expCount));
        checkOutput($sformatf("v%0d rdata", idx), 32'(b0.rdata), 32'(v.expRdata));
        checkOutput($sformatf("v%0d rempty", idx), 32'(b0.rempty), 32'(v.expEmpty));
        checkOutput($sformatf("v%0d wfull", idx), 32'(b0.wfull), 32'(v.expFull));
        checkOutput($sformatf("v%0d overflow", idx), 32'(b0.overflow), 32'(v.expOvf));
        checkOutput($sformatf("v%0d underflow", idx), 32'(b0.underflow), 32'(v.expUdf));
    endtask

    initial begin
        logic       wr, rd, wrOk, rdOk;
        logic [7:0] expRd;

        // Ordered stream, then overflow, full-with-both, drain and the underflow/clear corners
        addVec(1, 0, 0, 8'hAA, 1, 8'h00, 0, 0, 0, 0);
        addVec(1, 0, 0, 8'hBB, 2, 8'h00, 0, 0, 0, 0);
        addVec(1, 0, 0, 8'hCC, 3, 8'h00, 0, 0, 0, 0);
        addVec(1, 0, 0, 8'hDD, 4, 8'h00, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 3, 8'hAA, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 2, 8'hBB, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 1, 8'hCC, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 0, 8'hDD, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            addVec(1, 0, 0, 8'(i), 5'(i + 1), 8'hDD, 0, (i == 15), 0, 0);
        addVec(1, 0, 0, 8'h55, 16, 8'hDD, 0, 1, 1, 0);
        addVec(1, 1, 0, 8'h66, 15, 8'h00, 0, 0, 1, 0);
        for (int i = 1; i < 16; i++)
            addVec(0, 1, 0, 8'h00, 5'(15 - i), 8'(i), (i == 15), 0, 1, 0);
        addVec(0, 0, 1, 8'h00, 0, 8'h0F, 1, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 0, 8'h0F, 1, 0, 0, 1);
        addVec(0, 1, 1, 8'h00, 0, 8'h0F, 1, 0, 0, 1);
        addVec(0, 0, 1, 8'h00, 0, 8'h0F, 1, 0, 0, 0);

        b0.winc = 0; b0.rinc = 0; b0.clr_err = 0; b0.wdata = '0;
        b0.af_thresh = 5'd14; b0.ae_thresh = 5'd2;
        b1.winc = 0; b1.rinc = 0; b1.clr_err = 0; b1.wdata = '0;
        b1.af_thresh = 5'd0; b1.ae_thresh = 5'd0;

        tick();
        tick();
        checkOutput("rst count", 32'(b0.count), 0);
        checkOutput("rst rempty", 32'(b0.rempty), 1);
        checkOutput("rst wfull", 32'(b0.wfull), 0);
        checkOutput("rst almost_empty", 32'(b0.almost_empty), 1);
        checkOutput("rst almost_full", 32'(b0.almost_full), 0);
        checkOutput("rst almost_full af0", 32'(b1.almost_full), 1);
        checkOutput("rst rdata", 32'(b0.rdata), 0);
        checkOutput("rst overflow", 32'(b0.overflow), 0);
        checkOutput("rst underflow", 32'(b0.underflow), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkVec(i, vecs[i]);
        end

        // Threshold crossings while filling and draining
        for (int k = 1; k <= 16; k++) begin
            b0.winc = 1'b1; b0.wdata = 8'(k);
            tick();
            b0.winc = 1'b0;
            checkOutput($sformatf("fill%0d count", k), 32'(b0.count), 32'(k));
            checkOutput($sformatf("fill%0d almost_empty", k), 32'(b0.almost_empty), 32'(k <= 2));
            checkOutput($sformatf("fill%0d almost_full", k), 32'(b0.almost_full), 32'(k >= 14));
        end
        b0.af_thresh = 5'd17; b0.ae_thresh = 5'd17;
        #1;
        checkOutput("thr17 almost_full", 32'(b0.almost_full), 0);
        checkOutput("thr17 almost_empty", 32'(b0.almost_empty), 1);
        b0.af_thresh = 5'd14; b0.ae_thresh = 5'd2;
        for (int k = 15; k >= 0; k--) begin
            b0.rinc = 1'b1;
            tick();
            b0.rinc = 1'b0;
            checkOutput($sformatf("drain%0d rdata", k), 32'(b0.rdata), 32'(16 - k));
            checkOutput($sformatf("drain%0d almost_full", k), 32'(b0.almost_full), 32'(k >= 14));
            checkOutput($sformatf("drain%0d almost_empty", k), 32'(b0.almost_empty), 32'(k <= 2));
        end

        // FWFT instance: data visible without a read request
        b1.winc = 1'b1; b1.wdata = 8'h11;
        tick();
        b1.winc = 1'b0;
        checkOutput("fwft rempty after 11", 32'(b1.rempty), 0);
        checkOutput("fwft rdata 11", 32'(b1.rdata), 32'h11);
        b1.winc = 1'b1; b1.wdata = 8'h22;
        tick();
        b1.winc = 1'b0;
        checkOutput("fwft count 2", 32'(b1.count), 2);
        checkOutput("fwft rdata still 11", 32'(b1.rdata), 32'h11);
        b1.rinc = 1'b1;
        tick();
        b1.rinc = 1'b0;
        checkOutput("fwft rdata 22", 32'(b1.rdata), 32'h22);
        b1.winc = 1'b1; b1.rinc = 1'b1; b1.wdata = 8'h33;
        tick();
        b1.winc = 1'b0; b1.rinc = 1'b0;
        checkOutput("fwft both count", 32'(b1.count), 1);
        checkOutput("fwft both rdata", 32'(b1.rdata), 32'h33);
        b1.rinc = 1'b1;
        tick();
        b1.rinc = 1'b0;
        checkOutput("fwft empty", 32'(b1.rempty), 1);
        b1.winc = 1'b1; b1.rinc = 1'b1; b1.wdata = 8'h44;
        tick();
        b1.winc = 1'b0; b1.rinc = 1'b0;
        checkOutput("fwft empty both count", 32'(b1.count), 1);
        checkOutput("fwft empty both underflow", 32'(b1.underflow), 1);
        checkOutput("fwft empty both rdata", 32'(b1.rdata), 32'h44);

        // Asynchronous reset mid-cycle with a pending write
        b0.rinc = 1'b1;
        tick();
        b0.rinc = 1'b0;
        checkOutput("pre-rst underflow", 32'(b0.underflow), 1);
        for (int k = 0; k < 10; k++) begin
            b0.winc = 1'b1; b0.wdata = 8'(8'h90 + k);
            tick();
        end
        checkOutput("pre-rst count", 32'(b0.count), 10);
        b0.wdata = 8'hEE;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst count", 32'(b0.count), 0);
        checkOutput("async rst rempty", 32'(b0.rempty), 1);
        checkOutput("async rst overflow", 32'(b0.overflow), 0);
        checkOutput("async rst underflow", 32'(b0.underflow), 0);
        checkOutput("async rst rdata", 32'(b0.rdata), 0);
        b0.winc = 1'b0;
        tick();
        rst_n = 1'b1;
        b0.winc = 1'b1; b0.wdata = 8'h77;
        tick();
        b0.winc = 1'b0; b0.rinc = 1'b1;
        tick();
        b0.rinc = 1'b0;
        checkOutput("post-rst rdata", 32'(b0.rdata), 32'h77);
        checkOutput("post-rst count", 32'(b0.count), 0);

        // Wrap-around traffic against a queue model
        expRd = b0.rdata;
        for (int i = 0; i < 60; i++) begin
            wr = (i < 40);
            rd = (i >= 40) || ((i % 4) != 0);
            wrOk = wr && (model.size() < 16);
            rdOk = rd && (model.size() > 0);
            b0.winc = wr; b0.rinc = rd; b0.wdata = 8'(i * 7 + 3);
            tick();
            b0.winc = 1'b0; b0.rinc = 1'b0;
            if (rdOk) expRd = model.pop_front();
            if (wrOk) model.push_back(8'(i * 7 + 3));
            checkOutput($sformatf("wrap%0d count", i), 32'(b0.count), 32'(model.size()));
            checkOutput($sformatf("wrap%0d rdata", i), 32'(b0.rdata), 32'(expRd));
        end
        checkOutput("wrap end rempty", 32'(b0.rempty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
